// File: rtl/game_pkg.sv
// Shared scene encoding, life limit and
// binary-to-BCD helper for the game flow.
package game_pkg;

   typedef enum logic [1:0] {
      SCN_TITLE  = 2'b00,
      SCN_PLAY   = 2'b01,
      SCN_RESULT = 2'b10,
      SCN_OVER   = 2'b11
   } scene_e;

   localparam logic [1:0] MAX_LIFE = 2'd3;

   // 0..198 -> {hundreds, tens, ones}
   function automatic logic [11:0] to_bcd3(input logic [7:0] v);
      logic [7:0] r;
      logic [3:0] h;
      h = (v >= 8'd100) ? 4'd1 : 4'd0;
      r = (v >= 8'd100) ? v - 8'd100 : v;
      return {h, 4'(r / 8'd10), 4'(r % 8'd10)};
   endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// 4-digit BCD score accumulator; pins at
// 9999 instead of wrapping.
module bcd_score_acc
   import game_pkg::*;
(
   input  logic        clk_25m,
   input  logic        rst,
   input  logic        clr,
   input  logic        add_en,
   input  logic [11:0] addend,
   output logic [3:0]  score0,
   output logic [3:0]  score1,
   output logic [3:0]  score2,
   output logic [3:0]  score3
);

   logic [3:0][3:0] q;
   logic [3:0][3:0] add;
   logic [3:0][3:0] sum;
   logic [3:0][3:0] nxt;
   logic [4:0]      s;
   logic            c;

   // ripple-carry BCD add; carry out of the top digit saturates
   always_comb begin
      add = {4'd0, addend};
      sum = '0;
      s   = '0;
      c   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s = {1'b0, q[i]} + {1'b0, add[i]} + {4'd0, c};
         if (s > 5'd9) begin
            sum[i] = 4'(s - 5'd10);
            c      = 1'b1;
         end else begin
            sum[i] = s[3:0];
            c      = 1'b0;
         end
      end
      nxt = c ? 16'h9999 : sum;
   end

   // score register
   always_ff @(posedge clk_25m) begin
      if (rst || clr) begin
         q <= '0;
      end else if (add_en) begin
         q <= nxt;
      end
   end

   assign score0 = q[0];
   assign score1 = q[1];
   assign score2 = q[2];
   assign score3 = q[3];

endmodule

// File: rtl/scene_ctrl.sv
// Game-flow controller: scene FSM, lives,
// invulnerability blink and BCD score.
module scene_ctrl
   import game_pkg::*;
#(
   parameter int INVULN_FRAMES = 60,
   parameter int RESULT_FRAMES = 300,
   parameter int ENM_PTS       = 1,
   parameter int BOSS_PTS      = 50
) (
   input  logic       clk_25m,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       player_hit,
   input  logic       enemy_kill,
   input  logic       boss_kill,
   output logic [1:0] scene,
   output logic [1:0] life,
   output logic [3:0] score0,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [3:0] score3,
   output logic       reimu_vis,
   output logic       game_rst
);

   localparam int IW0 = $clog2(INVULN_FRAMES + 1);
   localparam int IW  = (IW0 < 3) ? 3 : IW0;
   localparam int HW  = $clog2(RESULT_FRAMES + 1);

   scene_e        st_q, st_nx;
   logic [1:0]    life_q, life_nx;
   logic [IW-1:0] inv_q, inv_nx;
   logic [HW-1:0] hold_q, hold_nx;
   logic          vis_q, vis_nx;
   logic          grst_q, grst_nx;
   logic          start_q, arm_q;
   logic          st_edge, hit_ok, clr, add_en;
   logic [7:0]    pts;

   // arm_q masks the first cycle after reset so a held button is no edge
   assign st_edge = start_btn & ~start_q & arm_q;
   assign hit_ok  = player_hit & ~boss_kill & (inv_q == '0);
   assign add_en  = (st_q == SCN_PLAY) & (enemy_kill | boss_kill);
   assign pts     = (enemy_kill ? 8'(ENM_PTS)  : 8'd0)
                  + (boss_kill  ? 8'(BOSS_PTS) : 8'd0);

   // start-button edge detector
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         start_q <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         start_q <= start_btn;
         arm_q   <= 1'b1;
      end
   end

   // next scene, lives, frame counters and output pulses
   always_comb begin
      st_nx   = st_q;
      life_nx = life_q;
      inv_nx  = inv_q;
      hold_nx = hold_q;
      grst_nx = 1'b0;
      clr     = 1'b0;
      unique case (st_q)
         SCN_TITLE: begin
            if (st_edge) begin
               st_nx   = SCN_PLAY;
               life_nx = MAX_LIFE;
               inv_nx  = '0;
               grst_nx = 1'b1;
               clr     = 1'b1;
            end
         end
         SCN_PLAY: begin
            if (frame_tick && inv_q != '0) begin
               inv_nx = inv_q - 1'b1;
            end
            if (boss_kill) begin
               st_nx   = SCN_RESULT;
               hold_nx = '0;
            end else if (hit_ok) begin
               life_nx = life_q - 2'd1;
               if (life_q == 2'd1) begin
                  st_nx   = SCN_OVER;
                  hold_nx = '0;
               end else begin
                  inv_nx = IW'(INVULN_FRAMES);
               end
            end
         end
         SCN_RESULT, SCN_OVER: begin
            if (st_edge) begin
               st_nx   = SCN_TITLE;
               grst_nx = 1'b1;
            end else if (frame_tick) begin
               hold_nx = HW'(hold_q + 1'b1);
               if (hold_nx == HW'(RESULT_FRAMES)) begin
                  st_nx   = SCN_TITLE;
                  grst_nx = 1'b1;
               end
            end
         end
         default: ;
      endcase
      vis_nx = (st_nx != SCN_PLAY) || (inv_nx == '0) || inv_nx[2];
   end

   // state and registered outputs
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         st_q   <= SCN_TITLE;
         life_q <= MAX_LIFE;
         inv_q  <= '0;
         hold_q <= '0;
         vis_q  <= 1'b1;
         grst_q <= 1'b0;
      end else begin
         st_q   <= st_nx;
         life_q <= life_nx;
         inv_q  <= inv_nx;
         hold_q <= hold_nx;
         vis_q  <= vis_nx;
         grst_q <= grst_nx;
      end
   end

   bcd_score_acc u_score (
      .clk_25m (clk_25m),
      .rst     (rst),
      .clr     (clr),
      .add_en  (add_en),
      .addend  (to_bcd3(pts)),
      .score0  (score0),
      .score1  (score1),
      .score2  (score2),
      .score3  (score3)
   );

   assign scene     = st_q;
   assign life      = life_q;
   assign reimu_vis = vis_q;
   assign game_rst  = grst_q;

endmodule

// File: doc/scene_ctrl.md
# scene_ctrl

Game-flow controller that sequences the VGA renderer. It runs the scene FSM (title, play, result, game over) and keeps the player life count, invulnerability blink and 4-digit BCD score. It drives the renderer's `scene`, `life`, `score0..3` and player-visibility inputs from gameplay events. It sits between the gameplay/collision logic and the pixel renderer, in the `clk_25m` domain.

## Interface
- `INVULN_FRAMES`, default 60: frames of invulnerability after a hit.
- `RESULT_FRAMES`, default 300: frames scene 10/11 is held before auto-return to title.
- `ENM_PTS`, default 1: points per enemy kill (0..99).
- `BOSS_PTS`, default 50: points per boss kill (0..99).

Ports:
- `clk_25m`  in  1: pixel clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `frame_tick`  in  1: one-cycle pulse per frame (start of vblank).
- `start_btn`  in  1: start button level, already synchronized.
- `player_hit`  in  1: one-cycle pulse, player collided with an enemy, enemy bullet or boss bullet.
- `enemy_kill`  in  1: one-cycle pulse, an enemy was destroyed.
- `boss_kill`  in  1: one-cycle pulse, the boss was destroyed.
- `scene`  out  2: 00 title, 01 play, 10 result (win), 11 game over.
- `life`  out  2: remaining lives, 0..3.
- `score3..score0`  out  4 each: BCD digits; score3 is the most significant.
- `reimu_vis`  out  1: player-sprite enable for the renderer.
- `game_rst`  out  1: one-cycle pulse that clears gameplay objects.

## Operation
- Scene FSM:
  - TITLE(00): on a `start_btn` rising edge, go to PLAY. On that transition, `life` becomes 3, score becomes 0000, invulnerability clears, and `game_rst` pulses.
  - PLAY(01):
    - `boss_kill` adds its points and goes to RESULT.
    - An accepted `player_hit` decrements `life`. If `life` reaches 0, go to OVER.
    - Otherwise start invulnerability (`INVULN_FRAMES`).
  - RESULT(10) / OVER(11):
    - Clear the hold counter on entry. Increment it on each `frame_tick`.
    - Go to TITLE when the counter reaches `RESULT_FRAMES` or on a `start_btn` rising edge, whichever comes first.
    - `game_rst` pulses on the transition to TITLE.
- Start edge detector: register the previous `start_btn`. A button held through reset does not count as an edge.
- `player_hit` is accepted only in PLAY while the invulnerability counter is 0. It is ignored otherwise.
- Score events are counted only in PLAY:
  - Increment = `enemy_kill`·`ENM_PTS` + `boss_kill`·`BOSS_PTS` (max 198), added in BCD with ripple carry across 4 digits.
  - Saturate at 9999; the score never wraps.
- Simultaneous events in one cycle:
  - `boss_kill` + `player_hit`: the hit is ignored, points are added, go to RESULT.
  - `enemy_kill` + `boss_kill`: both sums are added.
  - `enemy_kill` + `player_hit`: both take effect.
- `reimu_vis`:
  - 1 outside PLAY and when the invulnerability counter is 0.
  - While the counter is nonzero, `reimu_vis` = bit 2 of the counter, giving a 4-frame on/off blink.
- The invulnerability counter loads `INVULN_FRAMES` on an accepted hit and decrements on each `frame_tick` down to 0.
- `life` encoding matches the renderer's star display: 3→11, 2→10, 1→01, 0→00.

## Timing
- All outputs are registered. An input event in cycle N is visible on the outputs in cycle N+1.
- `game_rst` is high for exactly one cycle, coincident with the first cycle of the new `scene` value.
- Reset values: `scene`=00, `life`=11, `score3..0`=0, `reimu_vis`=1, `game_rst`=0. All counters and the start-edge register are cleared.
- `rst` overrides everything, including events in the same cycle. Reset mid-PLAY returns to TITLE without a `game_rst` pulse.
- Frame counters advance only on `frame_tick`. Events need not align with frames.
- If `frame_tick` coincides with an accepted hit, the load wins over the decrement.

## Structure
- Shared package `game_pkg`:
  - Scene encoding constants: `SCN_TITLE`, `SCN_PLAY`, `SCN_RESULT`, `SCN_OVER`.
  - `MAX_LIFE`=3.
  - Function converting 0..198 to BCD (hundreds, tens, ones).
- One sub-module, `bcd_score_acc`: 4-digit saturating BCD accumulator with ports `clk_25m`, `rst`, `clr`, `add_en`, 3-digit BCD addend, and 4 digit outputs.

## Test plan
- Reset, then `start_btn` 0→1: `scene` goes 00→01 the next cycle; `game_rst` pulses once; `life`=11; score=0000.
- In PLAY, 3 `enemy_kill` pulses then one `boss_kill` (defaults): score=0053, `scene`=10. After 300 `frame_tick`s, `scene`=00 and `game_rst` pulses.
- `player_hit`, then a second hit 10 frames later: `life`=10 and stays 10 (second hit ignored). `reimu_vis` toggles every 4 frames and returns to 1 after 60 frames.
- Three hits spaced more than 60 frames apart: `life` goes 10, 01, 00, and `scene`=11 one cycle after the third hit.
- Preload score 9990, then `boss_kill`: score saturates at 9999. Also, `boss_kill` and `player_hit` in the same cycle: `life` unchanged, `scene`=10.
- `rst` asserted mid-PLAY with score 0042: next cycle `scene`=00, score 0000, `life`=11, `game_rst`=0.
